// File: rtl/reg_bank_pkg.sv
// Shared constants and the index range check for the register-bank decoder.
package reg_bank_pkg;
    localparam int MAX_REGS = 16;

    function automatic logic idx_valid(input logic [31:0] sel, input int unsigned n);
        return sel < n;
    endfunction
endpackage

// File: rtl/reg_bank_cell.sv
// One bank register plus its one-cycle bus-write strobe flop.
module reg_bank_cell #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bus_we,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             hw_we,
    input  logic [WIDTH-1:0] hw_data,
    output logic [WIDTH-1:0] q,
    output logic             strb
);
    // Bus write has priority over a same-cycle hardware update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q    <= RST_VAL;
            strb <= 1'b0;
        end else begin
            strb <= bus_we;
            if (bus_we)     q <= bus_data;
            else if (hw_we) q <= hw_data;
        end
    end
endmodule

// File: rtl/reg_bank_demux.sv
// Register-bank write/read decoder: decode, storage cells, registered read and sticky error.
module reg_bank_demux
    import reg_bank_pkg::*;
#(
    parameter int                 N_REGS  = 2,
    parameter int                 WIDTH   = 32,
    parameter int                 ADDR_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic                     rd_i,
    input  logic [ADDR_W-1:0]        reg_sel_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     rd_valid_o,
    output logic [N_REGS-1:0]        wr_strb_o,
    output logic [N_REGS*WIDTH-1:0]  regs_o,
    input  logic [N_REGS-1:0]        hw_we_i,
    input  logic [N_REGS*WIDTH-1:0]  hw_data_i,
    output logic                     addr_err_o,
    input  logic                     err_clr_i
);
    logic [N_REGS-1:0][WIDTH-1:0] regs;
    logic [N_REGS-1:0][WIDTH-1:0] hw_data;
    logic [N_REGS-1:0]            bus_we;
    logic [WIDTH-1:0]             rd_mux;
    logic                         sel_ok;

    assign sel_ok  = idx_valid(32'(reg_sel_i), N_REGS);
    assign hw_data = hw_data_i;
    assign regs_o  = regs;

    for (genvar k = 0; k < N_REGS; k++) begin : g_cell
        assign bus_we[k] = wr_i && sel_ok && (reg_sel_i == ADDR_W'(k));

        reg_bank_cell #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_cell (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .bus_we   (bus_we[k]),
            .bus_data (data_i),
            .hw_we    (hw_we_i[k]),
            .hw_data  (hw_data[k]),
            .q        (regs[k]),
            .strb     (wr_strb_o[k])
        );
    end

    // Unmatched (out-of-range) indices fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_REGS; k++)
            if (reg_sel_i == ADDR_W'(k)) rd_mux = regs[k];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o     <= '0;
            rd_valid_o <= 1'b0;
            addr_err_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_i;
            if (rd_i) data_o <= rd_mux;
            if ((wr_i || rd_i) && !sel_ok) addr_err_o <= 1'b1;
            else if (err_clr_i)            addr_err_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_bank_demux.sv
// Directed bench: 4x8 bank for the main paths, 3x8 bank for out-of-range handling.
module tb_reg_bank_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_a = 0, rd_a = 0, clr_a = 0;
    logic [1:0]  sel_a = 0;
    logic [7:0]  din_a = 0, dout_a;
    logic        rdv_a, err_a;
    logic [3:0]  strb_a, hwwe_a = 0;
    logic [31:0] regs_a, hwd_a = 0;

    logic        wr_b = 0, rd_b = 0, clr_b = 0;
    logic [1:0]  sel_b = 0;
    logic [7:0]  din_b = 0, dout_b;
    logic        rdv_b, err_b;
    logic [2:0]  strb_b, hwwe_b = 0;
    logic [23:0] regs_b, hwd_b = 0;

    int checks = 0;
    int errors = 0;

    reg_bank_demux #(.N_REGS(4), .WIDTH(8), .RST_VAL(8'h5A)) u_a (
        .clk_i(clk), .rst_i(rst), .wr_i(wr_a), .rd_i(rd_a), .reg_sel_i(sel_a),
        .data_i(din_a), .data_o(dout_a), .rd_valid_o(rdv_a), .wr_strb_o(strb_a),
        .regs_o(regs_a), .hw_we_i(hwwe_a), .hw_data_i(hwd_a),
        .addr_err_o(err_a), .err_clr_i(clr_a)
    );

    reg_bank_demux #(.N_REGS(3), .WIDTH(8), .RST_VAL(8'hC3)) u_b (
        .clk_i(clk), .rst_i(rst), .wr_i(wr_b), .rd_i(rd_b), .reg_sel_i(sel_b),
        .data_i(din_b), .data_o(dout_b), .rd_valid_o(rdv_b), .wr_strb_o(strb_b),
        .regs_o(regs_b), .hw_we_i(hwwe_b), .hw_data_i(hwd_b),
        .addr_err_o(err_b), .err_clr_i(clr_b)
    );

    // Inputs change at negedge; one tick = capture edge, then back to negedge for checks.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        tick();
        checks++;
        if ({dout_a, rdv_a, strb_a, err_a} !== 14'h0) begin
            errors++; $display("FAIL reset_outs got %h exp 0", {dout_a, rdv_a, strb_a, err_a});
        end
        checks++;
        if (regs_a !== {4{8'h5A}}) begin
            errors++; $display("FAIL reset_regs got %h exp %h", regs_a, {4{8'h5A}});
        end
        rst = 1'b0;
        // Launch a write and a read, then hit reset between edges.
        wr_a = 1; rd_a = 1; sel_a = 1; din_a = 8'h33;
        tick();
        wr_a = 0; rd_a = 0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({strb_a, rdv_a, dout_a, err_a} !== 14'h0) begin
            errors++; $display("FAIL reset_midop got %h exp 0", {strb_a, rdv_a, dout_a, err_a});
        end
        checks++;
        if (regs_a !== {4{8'h5A}}) begin
            errors++; $display("FAIL reset_midop_regs got %h exp %h", regs_a, {4{8'h5A}});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        wr_a = 1; sel_a = 2; din_a = 8'hA5;
        tick();
        wr_a = 0;
        checks++;
        if (regs_a !== 32'h5AA55A5A) begin
            errors++; $display("FAIL wr_regs got %h exp 5aa55a5a", regs_a);
        end
        checks++;
        if (strb_a !== 4'b0100) begin
            errors++; $display("FAIL wr_strb got %b exp 0100", strb_a);
        end
        rd_a = 1; sel_a = 2;
        tick();
        rd_a = 0;
        checks++;
        if (strb_a !== 4'b0000) begin
            errors++; $display("FAIL wr_strb_drop got %b exp 0000", strb_a);
        end
        checks++;
        if ({rdv_a, dout_a} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL rd_a5 got %b/%h exp 1/a5", rdv_a, dout_a);
        end
        tick();
        checks++;
        if ({rdv_a, dout_a} !== {1'b0, 8'hA5}) begin
            errors++; $display("FAIL rd_hold got %b/%h exp 0/a5", rdv_a, dout_a);
        end
        checks++;
        if (err_a !== 1'b0) begin
            errors++; $display("FAIL err_valid_acc got %b exp 0", err_a);
        end
    endtask

    task automatic test_conflict;
        wr_a = 1; sel_a = 1; din_a = 8'h11;
        hwwe_a = 4'b0010; hwd_a = 32'h00002200;
        tick();
        wr_a = 0;
        checks++;
        if (regs_a[15:8] !== 8'h11 || strb_a !== 4'b0010) begin
            errors++; $display("FAIL conflict got %h/%b exp 11/0010", regs_a[15:8], strb_a);
        end
        tick();
        checks++;
        if (regs_a[15:8] !== 8'h22 || strb_a !== 4'b0000) begin
            errors++; $display("FAIL hw_only got %h/%b exp 22/0000", regs_a[15:8], strb_a);
        end
        hwwe_a = 4'b1001; hwd_a = 32'hD0_00_00_E0;
        tick();
        hwwe_a = 0;
        checks++;
        if (regs_a !== 32'hD0A522E0 || strb_a !== 4'b0000) begin
            errors++; $display("FAIL hw_multi got %h/%b exp d0a522e0/0000", regs_a, strb_a);
        end
    endtask

    task automatic test_rbw;
        wr_a = 1; sel_a = 0; din_a = 8'h03;
        tick();
        rd_a = 1; din_a = 8'h7F;
        tick();
        wr_a = 0; rd_a = 0;
        checks++;
        if ({rdv_a, dout_a} !== {1'b1, 8'h03}) begin
            errors++; $display("FAIL rbw_data got %b/%h exp 1/03", rdv_a, dout_a);
        end
        checks++;
        if (regs_a[7:0] !== 8'h7F || strb_a !== 4'b0001) begin
            errors++; $display("FAIL rbw_reg got %h/%b exp 7f/0001", regs_a[7:0], strb_a);
        end
    endtask

    task automatic test_out_of_range;
        rd_b = 1; sel_b = 0;
        tick();
        rd_b = 0;
        checks++;
        if (dout_b !== 8'hC3 || err_b !== 1'b0) begin
            errors++; $display("FAIL oor_pre got %h/%b exp c3/0", dout_b, err_b);
        end
        wr_b = 1; sel_b = 3; din_b = 8'hFF;
        tick();
        wr_b = 0;
        checks++;
        if (regs_b !== {3{8'hC3}} || strb_b !== 3'b000 || err_b !== 1'b1) begin
            errors++; $display("FAIL oor_wr got %h/%b/%b exp c3c3c3/000/1", regs_b, strb_b, err_b);
        end
        rd_b = 1;
        tick();
        rd_b = 0;
        checks++;
        if ({rdv_b, dout_b} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL oor_rd got %b/%h exp 1/00", rdv_b, dout_b);
        end
        tick();
        checks++;
        if (err_b !== 1'b1) begin
            errors++; $display("FAIL oor_sticky got %b exp 1", err_b);
        end
        clr_b = 1; rd_b = 1;
        tick();
        rd_b = 0;
        checks++;
        if (err_b !== 1'b1) begin
            errors++; $display("FAIL oor_set_wins got %b exp 1", err_b);
        end
        tick();
        clr_b = 0;
        checks++;
        if (err_b !== 1'b0) begin
            errors++; $display("FAIL oor_clear got %b exp 0", err_b);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            wr_a = 1; sel_a = 2'(i); din_a = 8'(8'h10 + i);
            tick();
            checks++;
            if (strb_a !== 4'(1 << i) || regs_a[i*8 +: 8] !== 8'(8'h10 + i)) begin
                errors++; $display("FAIL b2b_%0d got %b/%h exp %b/%h", i, strb_a,
                                   regs_a[i*8 +: 8], 4'(1 << i), 8'(8'h10 + i));
            end
        end
        wr_a = 0;
        tick();
        checks++;
        if (regs_a !== 32'h13121110 || strb_a !== 4'b0000) begin
            errors++; $display("FAIL b2b_final got %h/%b exp 13121110/0000", regs_a, strb_a);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_rbw();
        test_out_of_range();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_bank_demux.md
# reg_bank_demux

Parametrised register-bank write/read decoder for the lab peripherals. It generalises the two-register write-enable demux to N_REGS registers, holds the register storage, and adds several behaviours:
- one-cycle write strobes
- a registered read path with a valid pulse
- hardware-side register updates
- sticky out-of-range address error

It sits between the processor's memory-mapped bus slave and a peripheral core (UART, LED/switch block, etc.).

## Interface
Parameters:
- N_REGS, 2, number of registers (2..16)
- WIDTH, 32, register width in bits
- ADDR_W, $clog2(N_REGS) (minimum 1), width of reg_sel_i
- RST_VAL, '0, reset value of every register

Ports:
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, asynchronous, active-high
- wr_i  in  1  bus write request, single-cycle qualifier
- rd_i  in  1  bus read request, single-cycle qualifier
- reg_sel_i  in  ADDR_W  register index for wr_i/rd_i
- data_i  in  WIDTH  bus write data
- data_o  out  WIDTH  registered read data
- rd_valid_o  out  1  one-cycle pulse, data_o valid
- wr_strb_o  out  N_REGS  one-hot, one-cycle pulse per bus-written register
- regs_o  out  N_REGS*WIDTH  current register contents; register k at [k*WIDTH +: WIDTH]
- hw_we_i  in  N_REGS  per-register hardware write enable
- hw_data_i  in  N_REGS*WIDTH  hardware write data, same packing as regs_o
- addr_err_o  out  1  sticky flag: out-of-range access seen
- err_clr_i  in  1  clears addr_err_o

## Operation
- **Valid index:** reg_sel_i < N_REGS.
- **Bus write:** wr_i=1 with a valid index loads data_i into that register on the next rising edge. wr_strb_o[reg_sel_i] pulses high for exactly that following cycle.
- **Hardware write:** hw_we_i[k]=1 loads hw_data_i slice k into register k. Any number of registers may be written in the same cycle. A hardware write does not raise wr_strb_o.
- **Same-register conflict:** when a bus write and hw_we_i hit the same register in the same cycle, the bus write wins and the strobe still fires.
- **Bus read:**
  - rd_i=1 captures the selected register into data_o on the next edge, with rd_valid_o=1 for that cycle.
  - data_o holds its last value until the next read.
- **Simultaneous read and write:** wr_i and rd_i in the same cycle are both performed. A read of the register being written returns the old value (read-before-write).
- **Out-of-range index:**
  - A write is dropped: no register change, no strobe.
  - A read returns data_o=0 with rd_valid_o still pulsed.
  - Either case sets addr_err_o on the next edge.
- **Error clear:** err_clr_i clears addr_err_o. If a new error and err_clr_i occur in the same cycle, set wins.
- **No FSM:** there is no state machine; all state is the register array, the strobe/valid flops, data_o and the error flag.

## Timing
- **Reset values:**
  - every register = RST_VAL, so regs_o = RST_VAL in each slice
  - data_o = 0
  - rd_valid_o = 0
  - wr_strb_o = 0
  - addr_err_o = 0
- **Reset assertion mid-operation:** clears everything immediately (asynchronous), including an in-flight strobe or valid pulse.
- **Reset release:** the first edge after release may accept requests.
- **Write latency:** 1 cycle. regs_o shows the new value in the same cycle as the wr_strb_o pulse.
- **Read latency:** 1 cycle from rd_i to data_o/rd_valid_o.
- **Throughput:** back-to-back requests are accepted every cycle with no stall. There is no back-pressure; the bus always completes in one cycle.
- **Combinational paths:** regs_o is direct flop output; no combinational path from inputs to any output.

## Structure
- **Package reg_bank_pkg:** holds
  - max-channel constant MAX_REGS = 16
  - the typedef for the per-register slice type (logic [WIDTH-1:0]) as a parameterised helper where the tool allows; otherwise the constant only
  - function idx_valid(sel, n) for the range check
- **Sub-module reg_bank_cell:** one register with reset, bus-vs-hw priority, and its strobe flop. Instantiate it N_REGS times with a generate loop.
- **Top-level logic:** index decode, read mux/flop, and the error flag.

## Test plan
- **Reset:** assert rst_i mid-cycle with N_REGS=4, WIDTH=8 -> all outputs 0 immediately; regs_o = 4×RST_VAL.
- **Write then read:** wr_i, reg_sel_i=2, data_i=0xA5 -> next cycle regs_o[2]=0xA5 and wr_strb_o=4'b0100 for one cycle. rd_i, sel=2 -> data_o=0xA5, rd_valid_o=1 one cycle later.
- **Bus/hw conflict:** bus write 0x11 and hw_we_i[1] with 0x22 to register 1 in the same cycle -> reg1=0x11, wr_strb_o[1]=1. Next cycle hw-only 0x22 -> reg1=0x22, no strobe.
- **Read-before-write:** reg0=0x03, then rd_i and wr_i (0x7F) to reg0 in the same cycle -> data_o=0x03, reg0=0x7F.
- **Out-of-range:** N_REGS=3, write sel=3 with 0xFF -> no register changes, wr_strb_o=0, addr_err_o=1. Read sel=3 -> data_o=0, rd_valid_o=1. err_clr_i together with another bad access -> addr_err_o stays 1. err_clr_i alone -> 0.
- **Back-to-back:** writes to regs 0,1,2,3 on four consecutive cycles -> four consecutive one-hot strobes 0001, 0010, 0100, 1000; all values correct.
